// File: rtl/data_restore_pkg.sv
// Shared constants for the byte-increment stage and its receive-side restore.
package data_restore_pkg;

  localparam int DATA_W = 8;

  // Must match the offset added by the transmit-side processing stage.
  localparam logic [DATA_W-1:0] PROC_OFFSET = 8'h01;

  function automatic logic [DATA_W-1:0] restore_byte(input logic [DATA_W-1:0] d);
    return d - PROC_OFFSET;
  endfunction

endpackage

// File: rtl/data_restore_sync_fifo.sv
// Synchronous FIFO with registered head output (zero when empty); 1-cycle write-to-valid.
// Push while full is accepted only together with a pop; otherwise the write is ignored.
module sync_fifo #(
  parameter int DATA_W = data_restore_pkg::DATA_W,
  parameter int DEPTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [DATA_W-1:0]         push_data,
  input  logic                      pop,
  output logic [DATA_W-1:0]         head_data,
  output logic                      head_valid,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      full
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [LW-1:0]     after_pop, level_nxt;
  logic [DATA_W-1:0] head_nxt;
  logic              do_pop, do_push;

  assign do_pop  = pop && head_valid;
  assign do_push = push && (!full || do_pop);

  // The next head is the incoming byte only when nothing older survives this edge.
  always_comb begin
    after_pop  = level - LW'(do_pop);
    level_nxt  = after_pop + LW'(do_push);
    rd_ptr_nxt = rd_ptr + AW'(do_pop);
    head_nxt   = '0;
    if (level_nxt != '0) begin
      if (after_pop == '0) head_nxt = push_data;
      else                 head_nxt = mem[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      full       <= 1'b0;
      head_valid <= 1'b0;
      head_data  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr     <= rd_ptr_nxt;
      level      <= level_nxt;
      full       <= (level_nxt == LW'(DEPTH));
      head_valid <= (level_nxt != '0);
      head_data  <= head_nxt;
    end
  end

endmodule

// File: rtl/data_restore.sv
// Removes the transmit offset and buffers bytes on valid/ready; 1-cycle in-to-out latency.
// Input cannot be stalled: bytes arriving while full with no pop are dropped (overflow, DATA_RESTORE_STATS_EN adds drop_cnt).
module data_restore
  import data_restore_pkg::*;
#(
  parameter int DEPTH = 8
`ifdef DATA_RESTORE_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    full,
  output logic                    overflow
`ifdef DATA_RESTORE_STATS_EN
  , output logic [CNT_W-1:0]      drop_cnt
`endif
);

  logic pop;
  logic drop;

  assign pop  = out_valid && out_ready;
  assign drop = in_valid && full && !pop;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (in_valid),
    .push_data  (restore_byte(in_data)),
    .pop        (out_ready),
    .head_data  (out_data),
    .head_valid (out_valid),
    .level      (level),
    .full       (full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow <= 1'b0;
    else        overflow <= drop;
  end

`ifdef DATA_RESTORE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        drop_cnt <= '0;
    else if (drop && drop_cnt != '1)   drop_cnt <= drop_cnt + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_data_restore.sv
// Scoreboard bench for data_restore: queue-based reference model, directed cases plus random traffic.
module tb_data_restore;

  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;
`ifdef DATA_RESTORE_STATS_EN
  localparam int CNT_W = 16;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [LW-1:0] level;
  logic          full;
  logic          overflow;
`ifdef DATA_RESTORE_STATS_EN
  logic [CNT_W-1:0] drop_cnt;
`endif

  data_restore #(
    .DEPTH (DEPTH)
`ifdef DATA_RESTORE_STATS_EN
    , .CNT_W (CNT_W)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .full      (full),
    .overflow  (overflow)
`ifdef DATA_RESTORE_STATS_EN
    , .drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q [$];   // bytes the DUT should still hold, oldest first
  int         mdl_lvl = 0;
  int         mdl_drops = 0;
  bit         exp_ovf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_restore(input logic [7:0] d);
    return 8'((int'(d) + 255) % 256);
  endfunction

  // Apply one cycle of stimulus, let the edge happen, advance the model, check state.
  task automatic step(input bit v, input logic [7:0] d, input bit r);
    bit pop_m;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    #1;
    pop_m   = (mdl_lvl > 0) && r;
    exp_ovf = 1'b0;
    if (pop_m) mdl_lvl--;
    if (v) begin
      if (mdl_lvl < DEPTH) begin
        exp_q.push_back(ref_restore(d));
        mdl_lvl++;
      end else begin
        exp_ovf = 1'b1;
        mdl_drops++;
      end
    end
    chk("level", 32'(level), 32'(mdl_lvl));
    chk("full", 32'(full), 32'(mdl_lvl == DEPTH));
    chk("out_valid", 32'(out_valid), 32'(mdl_lvl > 0));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    if (mdl_lvl > 0 && exp_q.size() > 0) chk("head", 32'(out_data), 32'(exp_q[0]));
    else                                 chk("empty_data", 32'(out_data), 32'h0);
`ifdef DATA_RESTORE_STATS_EN
    chk("drop_cnt", 32'(drop_cnt), 32'(mdl_drops));
`endif
  endtask

  // Monitor: consumes expectations on every handshake and checks stall stability.
  bit         stall_pend = 1'b0;
  logic [7:0] stall_dat  = 8'h00;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        chk("stall_valid", 32'(out_valid), 32'h1);
        chk("stall_data", 32'(out_data), 32'(stall_dat));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL handshake: got 0x%0h expected no output", out_data);
        end else begin
          chk("pop_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
      stall_pend = out_valid && !out_ready;
      stall_dat  = out_data;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
`ifdef DATA_RESTORE_STATS_EN
    chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);
`endif

    // Single byte, ready already high: no pop on the push edge, one valid cycle.
    step(1'b1, 8'h05, 1'b1);
    chk("first_byte", 32'(out_data), 32'h04);
    step(1'b0, 8'h00, 1'b1);
    chk("drained", 32'(out_valid), 32'h0);

    step(1'b1, 8'h00, 1'b1);
    chk("wrap_ff", 32'(out_data), 32'hFF);
    step(1'b0, 8'h00, 1'b1);

    // Fill, overflow once, then drain.
    for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0);
    chk("fill_full", 32'(full), 32'h1);
    chk("fill_head", 32'(out_data), 32'h00);
    step(1'b1, 8'h09, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("ovf_one_pulse", 32'(overflow), 32'h0);
    for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b1);

    // Full with simultaneous push and pop: nothing dropped.
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    step(1'b1, 8'h81, 1'b1);
    chk("pushpop_level", 32'(level), 32'd8);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);

    // Continuous input with ready toggling.
    for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h10 + i), (i % 2) == 0);
    for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 1) == 1);

    // Reset with entries buffered.
    for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'h0);
    chk("midrst_level", 32'(level), 32'h0);
    chk("midrst_data", 32'(out_data), 32'h0);
    exp_q.delete();
    mdl_lvl   = 0;
    mdl_drops = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 8'h33, 1'b0);
    chk("post_rst_data", 32'(out_data), 32'h32);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
